// File: rtl/cache_pkg.sv
// Shared types for cache_set: FSM state codes, entry geometry and the per-way entry record.
// The entry is sized from the CACHE_* localparams; CACHE_SET_WRITEBACK_EN adds the dirty bit.
package cache_pkg;

  localparam int CACHE_WAYS     = 4;
  localparam int CACHE_DATA_W   = 8;
  localparam int CACHE_SET_BITS = 4;

  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int tag_w(input int set_bits);
    return 32 - set_bits;
  endfunction

  localparam int AGE_W = age_w(CACHE_WAYS);
  localparam int TAG_W = tag_w(CACHE_SET_BITS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOOKUP  = 3'd1;
  localparam logic [2:0] ST_FILL    = 3'd3;
  localparam logic [2:0] ST_RESPOND = 3'd5;
`ifdef CACHE_SET_WRITEBACK_EN
  localparam logic [2:0] ST_EVICT   = 3'd2;
`else
  localparam logic [2:0] ST_WTHRU   = 3'd4;
`endif

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic                    valid;
`ifdef CACHE_SET_WRITEBACK_EN
    logic                    dirty;
`endif
    logic [AGE_W-1:0]        age;
    logic [CACHE_DATA_W-1:0] data;
  } way_t;

endpackage

// File: rtl/cache_lru.sv
// Next-age vector for the set's LRU: accessed way becomes 0, younger valid ways age by one.
// Purely combinational; no handshake.
module cache_lru #(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age,
  input  logic [WAYS-1:0]            valid,
  input  logic [AGE_W-1:0]           idx,
  output logic [WAYS-1:0][AGE_W-1:0] age_next
);

  logic [AGE_W-1:0] ref_age;

  always_comb begin
    ref_age = age[idx];
    for (int i = 0; i < WAYS; i++) begin
      age_next[i] = age[i];
      if (AGE_W'(i) == idx)
        age_next[i] = '0;
      else if (valid[i] && (age[i] < ref_age))
        age_next[i] = age[i] + AGE_W'(1);
    end
  end

endmodule

// File: rtl/cache_set.sv
// One N-way cache set with LRU replacement; misses go to memory over a req/ack port.
// Hit read responds 2 cycles after accept; memory phases wait for mem_ack. Accepts only when idle.
// CACHE_SET_WRITEBACK_EN selects write-back with eviction; otherwise writes go through.
module cache_set
  import cache_pkg::*;
#(
  parameter int WAYS     = CACHE_WAYS,
  parameter int DATA_W   = CACHE_DATA_W,
  parameter int SET_BITS = CACHE_SET_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              is_empty,
  output logic              is_full
);

  localparam int IDX_W = AGE_W;

  logic [2:0]              state;
  logic                    lat_write;
  logic [31:0]             lat_addr;
  logic [DATA_W-1:0]       lat_wdata;
  way_t                    ways [WAYS];
  logic [IDX_W-1:0]        victim;

  logic [TAG_W-1:0]        lat_tag;
  logic [WAYS-1:0]         valid_vec;
  logic [WAYS-1:0][AGE_W-1:0] age_vec;
  logic [WAYS-1:0][AGE_W-1:0] age_next;
  logic                    hit;
  logic                    victim_found;
  logic [IDX_W-1:0]        hit_way;
  logic [IDX_W-1:0]        victim_c;
  logic [IDX_W-1:0]        lru_idx;
  logic [WAYS-1:0]         victim_oh;

  assign lat_tag   = lat_addr[31:SET_BITS];
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESPOND);
  assign victim_oh = WAYS'(1) << victim;
  // Ages are only rewritten on a hit in LOOKUP or on a completed fill.
  assign lru_idx   = (state == ST_LOOKUP) ? hit_way : victim;

  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim_c     = '0;
    victim_found = 1'b0;
    valid_vec    = '0;
    age_vec      = '0;
    for (int i = 0; i < WAYS; i++) begin
      valid_vec[i] = ways[i].valid;
      age_vec[i]   = ways[i].age;
      if (ways[i].valid && (ways[i].tag == lat_tag)) begin
        hit     = 1'b1;
        hit_way = IDX_W'(i);
      end
      if (!victim_found && !ways[i].valid) begin
        victim_found = 1'b1;
        victim_c     = IDX_W'(i);
      end
    end
    if (!victim_found) begin
      for (int i = 0; i < WAYS; i++)
        if (ways[i].age == AGE_W'(WAYS - 1)) victim_c = IDX_W'(i);
    end
  end

  cache_lru #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .age      (age_vec),
    .valid    (valid_vec),
    .idx      (lru_idx),
    .age_next (age_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      victim    <= '0;
      rsp_hit   <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      is_empty  <= 1'b1;
      is_full   <= 1'b0;
      for (int i = 0; i < WAYS; i++) begin
        ways[i].tag   <= '0;
        ways[i].valid <= 1'b0;
`ifdef CACHE_SET_WRITEBACK_EN
        ways[i].dirty <= 1'b0;
`endif
        ways[i].age   <= AGE_W'(i);
        ways[i].data  <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            state     <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          rsp_hit <= hit;
          if (hit) begin
            for (int i = 0; i < WAYS; i++) ways[i].age <= age_next[i];
            if (lat_write) begin
              ways[hit_way].data <= lat_wdata;
`ifdef CACHE_SET_WRITEBACK_EN
              ways[hit_way].dirty <= 1'b1;
`endif
              rsp_rdata <= lat_wdata;
            end else begin
              rsp_rdata <= ways[hit_way].data;
            end
`ifdef CACHE_SET_WRITEBACK_EN
            state <= ST_RESPOND;
`else
            state <= lat_write ? ST_WTHRU : ST_RESPOND;
`endif
          end else begin
            victim <= victim_c;
`ifdef CACHE_SET_WRITEBACK_EN
            state  <= (ways[victim_c].valid && ways[victim_c].dirty) ? ST_EVICT : ST_FILL;
`else
            state  <= ST_FILL;
`endif
          end
        end

`ifdef CACHE_SET_WRITEBACK_EN
        ST_EVICT: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {ways[victim].tag, lat_addr[SET_BITS-1:0]};
            mem_wdata <= ways[victim].data;
          end else if (mem_ack) begin
            mem_req             <= 1'b0;
            ways[victim].dirty  <= 1'b0;
            state               <= ST_FILL;
          end
        end
`endif

        ST_FILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= lat_addr;
          end else if (mem_ack) begin
            mem_req            <= 1'b0;
            ways[victim].tag   <= lat_tag;
            ways[victim].valid <= 1'b1;
            ways[victim].data  <= lat_write ? lat_wdata : mem_rdata;
`ifdef CACHE_SET_WRITEBACK_EN
            ways[victim].dirty <= lat_write;
`endif
            for (int i = 0; i < WAYS; i++) ways[i].age <= age_next[i];
            rsp_rdata <= lat_write ? lat_wdata : mem_rdata;
            is_empty  <= 1'b0;
            is_full   <= &(valid_vec | victim_oh);
`ifdef CACHE_SET_WRITEBACK_EN
            state <= ST_RESPOND;
`else
            state <= lat_write ? ST_WTHRU : ST_RESPOND;
`endif
          end
        end

`ifndef CACHE_SET_WRITEBACK_EN
        ST_WTHRU: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= lat_addr;
            mem_wdata <= lat_wdata;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_RESPOND;
          end
        end
`endif

        ST_RESPOND: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_set.sv
// Directed and random accesses to cache_set, checked against a recency-list model of the set.
module tb_cache_set;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_hit;
  logic [7:0]  rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        is_empty, is_full;

  cache_set #(.WAYS(4), .DATA_W(8), .SET_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .is_empty(is_empty), .is_full(is_full)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [7:0] wdata; } tr_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference set: tags/data per way plus a recency list, most recent first.
  logic [27:0] m_tag [4];
  bit          m_val [4];
  bit          m_dirty [4];
  logic [7:0]  m_data [4];
  int          lru_q[$];
  tr_t         exp_q[$];
  logic [7:0]  mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[11:4] ^ a[19:12] ^ 8'h3C;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
    lru_q.delete();
    exp_q.delete();
  endtask

  task automatic touch(input int k);
    for (int i = 0; i < lru_q.size(); i++)
      if (lru_q[i] == k) begin lru_q.delete(i); break; end
    lru_q.push_front(k);
  endtask

  task automatic model_access(input bit w, input logic [31:0] a, input logic [7:0] d,
                              output bit hit, output logic [7:0] rd);
    int k = -1;
    for (int i = 0; i < 4; i++) if (m_val[i] && m_tag[i] == a[31:4]) k = i;
    hit = (k >= 0);
    if (!hit) begin
      for (int i = 3; i >= 0; i--) if (!m_val[i]) k = i;
      if (k < 0) k = lru_q[lru_q.size()-1];
`ifdef CACHE_SET_WRITEBACK_EN
      if (m_val[k] && m_dirty[k]) exp_q.push_back('{1'b1, {m_tag[k], a[3:0]}, m_data[k]});
`endif
      exp_q.push_back('{1'b0, a, 8'h00});
      m_val[k] = 1; m_tag[k] = a[31:4]; m_data[k] = mem_rd(a); m_dirty[k] = 0;
    end
    if (w) begin
      m_data[k] = d;
`ifdef CACHE_SET_WRITEBACK_EN
      m_dirty[k] = 1;
`else
      exp_q.push_back('{1'b1, a, d});
`endif
    end
    touch(k);
    rd = m_data[k];
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_val[i]) n++;
    return n;
  endfunction

  task automatic reset_all();
    rst = 1'b1; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Issues one request at a negedge, plays memory, and checks the response.
  task automatic do_access(input bit w, input logic [31:0] a, input logic [7:0] d, input bit chk_lat);
    bit exp_hit, got, busy;
    logic [7:0] exp_rd;
    int cyc, wait_cnt;
    tr_t et;
    model_access(w, a, d, exp_hit, exp_rd);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 0; busy = 0; cyc = 0; wait_cnt = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_ack) begin
        mem_ack = 1'b0; mem_rdata = 8'($urandom);
        chk("mem_req_drop", mem_req, 0);
        busy = 0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1;
          wait_cnt = $urandom_range(0, 2);
          if (exp_q.size() == 0) chk("mem_unexpected", mem_req, 0);
          else begin
            et = exp_q.pop_front();
            chk("mem_we", mem_we, et.we);
            chk("mem_addr", mem_addr, et.addr);
            if (et.we) chk("mem_wdata", mem_wdata, et.wdata);
          end
        end
        if (wait_cnt == 0) begin
          if (mem_we) mem[mem_addr] = mem_wdata;
          mem_rdata = mem_we ? 8'($urandom) : mem_rd(mem_addr);
          mem_ack = 1'b1;
        end else wait_cnt--;
      end
      if (rsp_valid) begin
        got = 1;
        chk("rsp_hit", rsp_hit, exp_hit);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        if (chk_lat) chk("hit_latency", cyc, 2);
      end
    end
    chk("rsp_seen", got, 1);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("ready_after", req_ready, 1);
    chk("mem_pending", exp_q.size(), 0);
    chk("is_empty", is_empty, model_count() == 0);
    chk("is_full", is_full, model_count() == 4);
  endtask

  initial begin
    bit seen, rsp_seen;
    rst = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_is_empty", is_empty, 1);
    chk("rst_is_full", is_full, 0);
    rst = 1'b0;
    model_reset();

    mem[32'h0000_1230] = 8'hA5;
    do_access(0, 32'h0000_1230, 8'h00, 0);
    do_access(0, 32'h0000_1230, 8'h00, 1);

    reset_all();
    for (int t = 1; t <= 4; t++) do_access(0, t << 12, 8'h00, 0);
    do_access(0, 32'h0000_1000, 8'h00, 1);
    do_access(0, 32'h0000_5000, 8'h00, 0);
    do_access(0, 32'h0000_1000, 8'h00, 1);
    do_access(0, 32'h0000_2000, 8'h00, 0);

`ifdef CACHE_SET_WRITEBACK_EN
    reset_all();
    for (int t = 1; t <= 4; t++) do_access(0, t << 12, 8'h00, 0);
    do_access(1, 32'h0000_3000, 8'h3C, 0);
    do_access(0, 32'h0000_4000, 8'h00, 0);
    do_access(0, 32'h0000_1000, 8'h00, 0);
    do_access(0, 32'h0000_2000, 8'h00, 0);
    do_access(0, 32'h0000_6000, 8'h00, 0);
`else
    do_access(1, 32'h0000_1000, 8'h5A, 0);
`endif

    // Reset while a fill is outstanding.
    reset_all();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_9990; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_req;
    end
    chk("fill_req_seen", seen, 1);
    chk("fill_mem_we", mem_we, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_req_ready", req_ready, 1);
    chk("rstmid_is_empty", is_empty, 1);
    rsp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || mem_req) rsp_seen = 1;
    end
    chk("rstmid_quiet", rsp_seen, 0);
    model_reset();

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = {16'h0, 4'($urandom_range(1, 6)), 8'h00, 4'($urandom)};
      do_access(1'($urandom), a, 8'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_set.md
# cache_set

N-way set-associative cache set: the parametrised successor to the single cache line. Holds WAYS lines, each with a tag, valid bit, per-way LRU age counter and DATA_W-bit data. Misses are serviced from backing memory through a request/acknowledge port. Sits between the upstream set-index decoder and the memory interface; one instance per set.

## Interface
- WAYS, 4, number of ways; power of two, ≥2
- DATA_W, 8, data width in bits
- SET_BITS, 4, low address bits consumed by upstream set/offset decode; tag = req_addr[31:SET_BITS]
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_hit  out  1  1 = request hit, valid with rsp_valid
- rsp_rdata  out  DATA_W  line data after the operation, valid with rsp_valid
- mem_req  out  1  memory transaction request
- mem_we  out  1  memory transaction is a write
- mem_addr  out  32  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory transaction complete; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  memory read data
- is_empty  out  1  no valid ways
- is_full  out  1  all ways valid

## Operation
- States: IDLE, LOOKUP, EVICT, FILL, WTHRU, RESPOND. EVICT exists only with the macro; WTHRU only without it.
- IDLE: req_ready=1. req_valid&req_ready latches req_write, req_addr and req_wdata, then moves to LOOKUP. Requests at any other time are ignored, not queued.
- LOOKUP: hit = any valid way with matching tag.
  - Hit: update data if write, then go to WTHRU (macro off, write) or RESPOND.
  - Miss: select victim = lowest-index invalid way, else the way with age==WAYS-1. Go to EVICT if the victim is valid and dirty (macro on), else FILL.
- FILL: mem_req=1, mem_we=0, mem_addr=req_addr. On mem_ack: victim gets tag, valid=1, data=mem_rdata. On a write, data is then overwritten with req_wdata (write-allocate). Next state is WTHRU (macro off, write) or RESPOND.
- RESPOND: rsp_valid=1 for one cycle, then IDLE.
- LRU: every completed access to way k sets age[k]=0 and increments each valid way whose age < old age[k]. Ages stay a permutation of 0..WAYS-1.
- Reset: all valid/dirty=0; age[i]=i; state IDLE. Outputs reset to req_ready=1, rsp_valid=0, rsp_hit=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, is_empty=1, is_full=0.

## Timing
- Accept edge E0. LOOKUP runs in cycle E0→E1. Hit without write-through: rsp_valid high in cycle E1→E2, req_ready high again from E2.
- Memory handshake: mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until mem_ack is sampled high. mem_req drops on that edge. mem_ack while mem_req=0 is ignored. No timeout.
- Each memory transaction adds ≥2 cycles: entry edge, then the ack edge.
- rst has priority over every other event in the same cycle. Mid-transaction, mem_req=0 after the next edge, the pending request is dropped, and no rsp_valid is issued.
- is_empty and is_full are registered and updated on the edge that changes any valid bit.

## Configuration
- CACHE_SET_WRITEBACK_EN defined (write-back):
  - Per-way dirty bit; write hit or write-allocate sets dirty.
  - EVICT: mem_we=1, mem_addr={victim_tag, req_addr[SET_BITS-1:0]}, mem_wdata=victim data; dirty cleared on ack, then FILL.
- Undefined (write-through):
  - No dirty bits and no EVICT state.
  - Every write ends in WTHRU: mem_we=1, mem_addr=req_addr, mem_wdata=req_wdata; RESPOND after ack.

## Structure
- cache_pkg: state enum; AGE_W=$clog2(WAYS) and TAG_W=32-SET_BITS as functions/localparams; the way-entry struct (tag, valid, dirty, age, data).
- Sub-module cache_lru: combinational next-age vector from current ages, valid bits and accessed way index.

## Test plan
WAYS=4, DATA_W=8, SET_BITS=4.
- Reset, then read 0x0000_1230 → mem_req with mem_addr 0x0000_1230; mem_ack with rdata 0xA5 → rsp_valid, rsp_hit=0, rsp_rdata=0xA5; is_empty=0.
- Same read again → rsp_valid 2 cycles after accept, rsp_hit=1, rsp_rdata 0xA5, mem_req stays 0.
- Fill tags 0x100..0x400 (ways 0-3, is_full=1), reread tag 0x100, then read tag 0x500 → victim is way 1 (tag 0x200); a later read of tag 0x100 hits.
- Macro on: write 0x3C hit to way 2, force eviction of way 2 → mem_we=1, mem_wdata=0x3C, old address; then FILL read.
- Reset asserted while mem_req=1 in FILL → next cycle mem_req=0, req_ready=1, is_empty=1, no rsp_valid ever.
- Macro off: write 0x5A hit → mem_we=1, mem_wdata=0x5A; rsp_valid only after mem_ack, rsp_rdata=0x5A.
